// File: rtl/uart_rx_cfg_arbiter_if.sv
// rtl/uart_rx_cfg_arbiter_if.sv - requester and receiver-config streams of the config arbiter
interface uart_rx_cfg_arbiter_if #(
    parameter int unsigned NUM_REQ = 2
) ();
    logic [27*NUM_REQ-1:0] s_req_tdata;
    logic [NUM_REQ-1:0]    s_req_tvalid;
    logic [NUM_REQ-1:0]    s_req_tready;
    logic [26:0]           m_axis_config_tdata;
    logic                  m_axis_config_tvalid;
    logic                  m_axis_config_tready;

    modport slave (
        input  s_req_tdata,
        input  s_req_tvalid,
        output s_req_tready,
        output m_axis_config_tdata,
        output m_axis_config_tvalid,
        input  m_axis_config_tready
    );

    modport master (
        output s_req_tdata,
        output s_req_tvalid,
        input  s_req_tready,
        input  m_axis_config_tdata,
        input  m_axis_config_tvalid,
        output m_axis_config_tready
    );
endinterface

// File: rtl/uart_rx_cfg_arbiter.sv
// rtl/uart_rx_cfg_arbiter.sv - round-robin arbiter feeding one config word at a time to the UART receiver
module uart_rx_cfg_arbiter #(
    parameter int unsigned NUM_REQ        = 2,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter logic [26:0] DEFAULT_CONFIG = 27'h140000C
) (
    input  logic                        aclk,
    input  logic                        aresetn,
    uart_rx_cfg_arbiter_if.slave        bus,
    output logic [26:0]                 active_config,
    output logic [1:0]                  active_src,
    output logic [15:0]                 cfg_count,
    output logic                        busy,
    output logic                        timeout_err,
    input  logic                        clear_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_ISSUE = 2'd2
    } state_t;

    localparam logic [15:0] TMAX    = 16'(TIMEOUT_CYCLES);
    localparam logic [15:0] TMAX_M1 = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0]  LAST    = 2'(NUM_REQ - 1);

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic [1:0]  rr_ptr_q, rr_ptr_d;
    logic [26:0] hold_q, hold_d;
    logic [26:0] act_cfg_q, act_cfg_d;
    logic [1:0]  act_src_q, act_src_d;
    logic [15:0] count_q, count_d;
    logic [15:0] tcnt_q, tcnt_d;
    logic        err_q, err_d;

    logic        win_found;
    logic [1:0]  win_idx;
    logic [2:0]  cand;
    logic        valid_g;
    logic [26:0] data_g;
    logic        set_err;

    // Round-robin search: first valid requester at or above rr_ptr, wrapping at NUM_REQ.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 2'd0;
        cand      = 3'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = {1'b0, rr_ptr_q} + 3'(k);
            if (cand >= 3'(NUM_REQ)) begin
                cand = cand - 3'(NUM_REQ);
            end
            for (int j = 0; j < NUM_REQ; j++) begin
                if (!win_found && cand == 3'(j) && bus.s_req_tvalid[j]) begin
                    win_found = 1'b1;
                    win_idx   = 2'(j);
                end
            end
        end
    end

    always_comb begin
        valid_g = 1'b0;
        data_g  = 27'd0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (grant_q == 2'(j)) begin
                valid_g = bus.s_req_tvalid[j];
                data_g  = bus.s_req_tdata[j*27 +: 27];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_ptr_d  = rr_ptr_q;
        hold_d    = hold_q;
        act_cfg_d = act_cfg_q;
        act_src_d = act_src_q;
        count_d   = count_q;
        tcnt_d    = tcnt_q;
        set_err   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (win_found) begin
                    grant_d = win_idx;
                    state_d = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (valid_g) begin
                    hold_d  = data_g;
                    tcnt_d  = 16'd0;
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (bus.m_axis_config_tready) begin
                    act_cfg_d = hold_q;
                    act_src_d = grant_q;
                    count_d   = count_q + 16'd1;
                    rr_ptr_d  = (grant_q == LAST) ? 2'd0 : grant_q + 2'd1;
                    state_d   = ST_IDLE;
                end else begin
                    // Stall counter saturates; the word stays held regardless.
                    if (tcnt_q != TMAX) begin
                        tcnt_d = tcnt_q + 16'd1;
                    end
                    if (tcnt_q >= TMAX_M1) begin
                        set_err = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        err_d = set_err ? 1'b1 : (clear_err ? 1'b0 : err_q);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q   <= ST_IDLE;
            grant_q   <= 2'd0;
            rr_ptr_q  <= 2'd0;
            hold_q    <= 27'd0;
            act_cfg_q <= DEFAULT_CONFIG;
            act_src_q <= 2'd0;
            count_q   <= 16'd0;
            tcnt_q    <= 16'd0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_ptr_q  <= rr_ptr_d;
            hold_q    <= hold_d;
            act_cfg_q <= act_cfg_d;
            act_src_q <= act_src_d;
            count_q   <= count_d;
            tcnt_q    <= tcnt_d;
            err_q     <= err_d;
        end
    end

    always_comb begin
        bus.s_req_tready = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            bus.s_req_tready[j] = (state_q == ST_GRANT) && (grant_q == 2'(j));
        end
    end

    assign bus.m_axis_config_tdata  = hold_q;
    assign bus.m_axis_config_tvalid = (state_q == ST_ISSUE);
    assign active_config            = act_cfg_q;
    assign active_src               = act_src_q;
    assign cfg_count                = count_q;
    assign busy                     = (state_q != ST_IDLE);
    assign timeout_err              = err_q;

endmodule

// File: tb/tb_uart_rx_cfg_arbiter.sv
// tb/tb_uart_rx_cfg_arbiter.sv - scoreboard bench for uart_rx_cfg_arbiter with a queue-based arbitration model
module tb_uart_rx_cfg_arbiter;

    localparam int          NR  = 3;
    localparam int          TO  = 50;
    localparam logic [26:0] DEF = 27'h140000C;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic        clear_err = 1'b0;
    logic [26:0] active_config;
    logic [1:0]  active_src;
    logic [15:0] cfg_count;
    logic        busy;
    logic        timeout_err;

    uart_rx_cfg_arbiter_if #(.NUM_REQ(NR)) bus ();

    uart_rx_cfg_arbiter #(
        .NUM_REQ(NR),
        .TIMEOUT_CYCLES(TO),
        .DEFAULT_CONFIG(DEF)
    ) dut (
        .aclk(aclk),
        .aresetn(aresetn),
        .bus(bus),
        .active_config(active_config),
        .active_src(active_src),
        .cfg_count(cfg_count),
        .busy(busy),
        .timeout_err(timeout_err),
        .clear_err(clear_err)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [26:0] data;
        logic [1:0]  src;
        logic [15:0] cnt;
    } exp_t;

    int          n_vec = 0;
    int          n_err = 0;
    exp_t        exp_q[$];
    logic [26:0] rq[NR][$];
    logic [26:0] bq[NR][$];
    int          model_rr = 0;
    logic [15:0] model_count = 16'd0;
    int          ds_mode = 1;
    bit          withdraw = 1'b0;
    bit          mon_pend = 1'b0;
    int          chg[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Expected downstream order from the arbitration rules: each requester offers its
    // pending words in turn, the first non-empty index at or after the pointer wins.
    task automatic commit_batch();
        int   rr;
        int   found;
        exp_t e;
        rr = model_rr;
        forever begin
            found = -1;
            for (int k = 0; k < NR; k++) begin
                int idx;
                idx = (rr + k) % NR;
                if (found < 0 && bq[idx].size() > 0) found = idx;
            end
            if (found < 0) break;
            e.data = bq[found].pop_front();
            e.src  = 2'(found);
            model_count++;
            e.cnt  = model_count;
            rq[found].push_back(e.data);
            exp_q.push_back(e);
            rr = (found + 1) % NR;
        end
        model_rr = rr;
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            bus.s_req_tvalid[i] = (rq[i].size() > 0) && !(withdraw && bus.s_req_tready[i]);
            bus.s_req_tdata[i*27 +: 27] = (rq[i].size() > 0) ? rq[i][0] : 27'd0;
        end
        case (ds_mode)
            0:       bus.m_axis_config_tready = ($urandom_range(3) != 0);
            1:       bus.m_axis_config_tready = 1'b1;
            default: bus.m_axis_config_tready = 1'b0;
        endcase
    endtask

    task automatic step();
        bit pop[NR];
        @(negedge aclk);
        for (int i = 0; i < NR; i++) pop[i] = bus.s_req_tready[i] && bus.s_req_tvalid[i];
        @(posedge aclk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (pop[i] && rq[i].size() > 0) void'(rq[i].pop_front());
        end
        drive();
    endtask

    function automatic bit rq_empty();
        for (int i = 0; i < NR; i++) if (rq[i].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic drain(input string name, output int nv, output int nt0);
        int          n;
        logic [15:0] prev;
        n    = 0;
        nv   = 0;
        nt0  = 0;
        prev = cfg_count;
        chg.delete();
        while ((exp_q.size() != 0 || mon_pend || busy || !rq_empty()) && n < 600) begin
            step();
            n++;
            if (bus.m_axis_config_tvalid) nv++;
            if (bus.s_req_tready[0]) nt0++;
            if (cfg_count != prev) chg.push_back(n);
            prev = cfg_count;
        end
        if (n >= 600) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_drain: still busy after %0d cycles, %0d words outstanding", name, n, exp_q.size());
        end
    endtask

    initial begin : monitor
        exp_t e;
        exp_t last;
        forever begin
            @(negedge aclk);
            if (!aresetn) begin
                mon_pend = 1'b0;
            end else begin
                if (mon_pend) begin
                    chk("active_config", 32'(active_config), 32'(last.data));
                    chk("active_src", 32'(active_src), 32'(last.src));
                    chk("cfg_count", 32'(cfg_count), 32'(last.cnt));
                    mon_pend = 1'b0;
                end
                if (bus.m_axis_config_tvalid && bus.m_axis_config_tready) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL unexpected_word: got %h expected no transfer", bus.m_axis_config_tdata);
                    end else begin
                        e = exp_q.pop_front();
                        chk("m_tdata", 32'(bus.m_axis_config_tdata), 32'(e.data));
                        last     = e;
                        mon_pend = 1'b1;
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int          nv;
        int          nt0;
        int          n;
        bit          ok;
        logic [26:0] held;

        bus.s_req_tdata          = '0;
        bus.s_req_tvalid         = '0;
        bus.m_axis_config_tready = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        aresetn = 1'b1;

        chk("rst_active_config", 32'(active_config), 32'(DEF));
        chk("rst_cfg_count", 32'(cfg_count), 32'd0);
        chk("rst_active_src", 32'(active_src), 32'd0);
        chk("rst_m_tvalid", 32'(bus.m_axis_config_tvalid), 32'd0);
        chk("rst_m_tdata", 32'(bus.m_axis_config_tdata), 32'd0);
        chk("rst_s_tready", 32'(bus.s_req_tready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);

        // Single word from requester 0 with the receiver always ready.
        ds_mode = 1;
        bq[0].push_back(27'h0000068);
        commit_batch();
        drain("single", nv, nt0);
        chk("single_tvalid_cycles", 32'(nv), 32'd1);
        chk("single_tready0_cycles", 32'(nt0), 32'd1);
        chk("single_active_config", 32'(active_config), 32'h0000068);
        chk("single_active_src", 32'(active_src), 32'd0);
        chk("single_cfg_count", 32'(cfg_count), 32'd1);

        // Highest index wraps the pointer back to 0.
        bq[2].push_back(27'h3ABCDEF);
        commit_batch();
        drain("wrap", nv, nt0);
        chk("wrap_active_src", 32'(active_src), 32'd2);

        // Two requesters continuously valid: A,B,A,B every 3 cycles.
        bq[0].push_back(27'h1);
        bq[0].push_back(27'h1);
        bq[1].push_back(27'h2);
        bq[1].push_back(27'h2);
        commit_batch();
        drain("fair", nv, nt0);
        chk("fair_updates", 32'(chg.size()), 32'd4);
        for (int i = 1; i < chg.size(); i++) begin
            chk("fair_spacing", 32'(chg[i] - chg[i-1]), 32'd3);
        end
        chk("fair_cfg_count", 32'(cfg_count), 32'(model_count));

        // Receiver busy for 100 cycles; timeout after 50 stalled ISSUE cycles.
        ds_mode = 2;
        bq[1].push_back(27'($urandom));
        commit_batch();
        n = 0;
        while (!bus.m_axis_config_tvalid && n < 10) begin
            step();
            n++;
        end
        chk("stall_tvalid_seen", 32'(bus.m_axis_config_tvalid), 32'd1);
        held = bus.m_axis_config_tdata;
        ok   = 1'b1;
        for (int k = 1; k <= 100; k++) begin
            step();
            if (!bus.m_axis_config_tvalid || bus.m_axis_config_tdata !== held) ok = 1'b0;
            if (k == TO - 1) chk("stall_err_before", 32'(timeout_err), 32'd0);
            if (k == TO) chk("stall_err_at", 32'(timeout_err), 32'd1);
        end
        chk("stall_stable", 32'(ok), 32'd1);
        ds_mode = 1;
        drain("stall", nv, nt0);
        chk("stall_err_sticky", 32'(timeout_err), 32'd1);
        chk("stall_cfg_count", 32'(cfg_count), 32'(model_count));

        clear_err = 1'b1;
        step();
        clear_err = 1'b0;
        chk("clear_err", 32'(timeout_err), 32'd0);

        // Requester 1 drops valid whenever granted: no transfer, pointer untouched.
        withdraw = 1'b1;
        rq[1].push_back(27'h0000055);
        nv  = 0;
        nt0 = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (bus.m_axis_config_tvalid) nv++;
            if (bus.s_req_tready[1]) nt0++;
        end
        rq[1].delete();
        repeat (2) step();
        withdraw = 1'b0;
        repeat (2) step();
        chk("wd_no_tvalid", 32'(nv), 32'd0);
        chk("wd_granted", 32'(nt0 > 0), 32'd1);
        chk("wd_busy", 32'(busy), 32'd0);
        chk("wd_cfg_count", 32'(cfg_count), 32'(model_count));

        // Random batches against the model, random receiver readiness.
        ds_mode = 0;
        for (int b = 0; b < 25; b++) begin
            for (int i = 0; i < NR; i++) begin
                int cnt;
                cnt = $urandom_range(3);
                for (int w = 0; w < cnt; w++) bq[i].push_back(27'($urandom));
            end
            commit_batch();
            drain("random", nv, nt0);
        end
        chk("random_cfg_count", 32'(cfg_count), 32'(model_count));

        // Reset while a word is being issued.
        ds_mode = 2;
        bq[0].push_back(27'h1234567);
        commit_batch();
        n = 0;
        while (!bus.m_axis_config_tvalid && n < 10) begin
            step();
            n++;
        end
        chk("rstmid_tvalid_seen", 32'(bus.m_axis_config_tvalid), 32'd1);
        #2;
        aresetn = 1'b0;
        #1;
        chk("rstmid_m_tvalid", 32'(bus.m_axis_config_tvalid), 32'd0);
        chk("rstmid_m_tdata", 32'(bus.m_axis_config_tdata), 32'd0);
        chk("rstmid_s_tready", 32'(bus.s_req_tready), 32'd0);
        chk("rstmid_active_config", 32'(active_config), 32'(DEF));
        chk("rstmid_cfg_count", 32'(cfg_count), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        for (int i = 0; i < NR; i++) rq[i].delete();
        exp_q.delete();
        model_rr    = 0;
        model_count = 16'd0;
        ds_mode     = 1;
        repeat (2) step();
        aresetn = 1'b1;
        repeat (3) step();
        chk("postrst_active_config", 32'(active_config), 32'(DEF));
        chk("postrst_cfg_count", 32'(cfg_count), 32'd0);

        bq[1].push_back(27'h7654321);
        commit_batch();
        drain("postrst", nv, nt0);
        chk("postrst_transfer_count", 32'(cfg_count), 32'd1);
        chk("postrst_transfer_src", 32'(active_src), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
